// File: rtl/i2s_transmit1.sv
// i2s_transmit1: I2S transmitter on the bit clock with a small sample-pair FIFO, 64-sck frames, MSB-first.
module i2s_transmit1 #(
    parameter int DATA_BITS = 32,
    parameter int DEPTH = 4
) (
    input  logic                     sck,
    input  logic                     rst,
    input  logic [31:0]              in_left,
    input  logic [31:0]              in_right,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     mute,
    input  logic                     clr_underrun,
    output logic                     ws,
    output logic                     sd,
    output logic                     frame_start,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] MASK = ~(32'hFFFF_FFFF >> DATA_BITS);
    logic [63:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic [5:0]  f, f_n;
    logic [63:0] shreg, word;
    logic        started, load, push, pop, empty, full;
    assign level    = wp - rp;
    assign empty    = wp == rp;
    assign full     = level == (AW+1)'(DEPTH);
    assign in_ready = !rst && !full;
    assign push     = in_valid && in_ready;
    assign load     = f == 6'd63;
    assign pop      = load && !empty;
    assign f_n      = f + 6'd1;
    // Empty FIFO and muted frames both go out as silence; the pop decision uses the registered pointers only.
    always_comb word = (pop && !mute) ? (mem[rp[AW-1:0]] & {MASK, MASK}) : '0;
    always_ff @(posedge sck)
        if (push) mem[wp[AW-1:0]] <= {in_left, in_right};
    always_ff @(posedge sck) begin
        if (rst) begin
            f           <= 6'd63;
            wp          <= '0;
            rp          <= '0;
            started     <= 1'b0;
            underrun    <= 1'b0;
            shreg       <= '0;
            ws          <= 1'b0;
            sd          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            f           <= f_n;
            wp          <= wp + (AW+1)'(push);
            rp          <= rp + (AW+1)'(pop);
            started     <= started || pop;
            underrun    <= (load && empty && started) || (underrun && !clr_underrun);
            shreg       <= load ? word << 1 : shreg << 1;
            sd          <= load ? word[63] : shreg[63];
            ws          <= f_n >= 6'd31 && f_n <= 6'd62;
            frame_start <= f_n == 6'd0;
        end
    end
endmodule

// File: tb/tb_i2s_transmit1.sv
// tb_i2s_transmit1: scoreboard bench; frames are reassembled from sd/ws and matched against queued expectations.
module tb_i2s_transmit1;
    logic        sck = 0, rst = 1, in_valid = 0, mute = 0, clr_underrun = 0;
    logic [31:0] in_left = 0, in_right = 0;
    logic        ws, sd, frame_start, underrun, in_ready;
    logic        ws24, sd24, fs24, ur24, rdy24;
    logic [2:0]  level, lvl24;
    int          total = 0, bad = 0, cyc = 0;
    logic [63:0] q32[$], q24[$];
    localparam logic [63:0] WS_PAT = 64'h0000_0001_FFFF_FFFE;

    always #5 sck = ~sck;

    i2s_transmit1 #(.DATA_BITS(32), .DEPTH(4)) dut (
        .sck(sck), .rst(rst), .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
        .in_ready(in_ready), .mute(mute), .clr_underrun(clr_underrun), .ws(ws), .sd(sd),
        .frame_start(frame_start), .underrun(underrun), .level(level));

    i2s_transmit1 #(.DATA_BITS(24), .DEPTH(4)) dut24 (
        .sck(sck), .rst(rst), .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
        .in_ready(rdy24), .mute(mute), .clr_underrun(clr_underrun), .ws(ws24), .sd(sd24),
        .frame_start(fs24), .underrun(ur24), .level(lvl24));

    always @(posedge sck) cyc = rst ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void expect_frame(input logic [63:0] w);
        q32.push_back(w);
        q24.push_back(w & {32'hFFFF_FF00, 32'hFFFF_FF00});
    endfunction

    int c32 = -1, c24 = -1;
    logic [63:0] s32, w32, s24, w24;

    always @(negedge sck) begin
        if (rst) c32 = -1;
        else begin
            if (frame_start) c32 = 0;
            if (c32 >= 0) begin
                s32 = {s32[62:0], sd};
                w32 = {w32[62:0], ws};
                c32++;
                if (c32 == 64) begin
                    c32 = -1;
                    if (q32.size() == 0) begin
                        total++; bad++;
                        $display("FAIL frame32: got %h want none", s32);
                    end else chk("frame32", s32, q32.pop_front());
                    chk("ws32", w32, WS_PAT);
                end
            end
        end
    end

    always @(negedge sck) begin
        if (rst) c24 = -1;
        else begin
            if (fs24) c24 = 0;
            if (c24 >= 0) begin
                s24 = {s24[62:0], sd24};
                w24 = {w24[62:0], ws24};
                c24++;
                if (c24 == 64) begin
                    c24 = -1;
                    if (q24.size() == 0) begin
                        total++; bad++;
                        $display("FAIL frame24: got %h want none", s24);
                    end else chk("frame24", s24, q24.pop_front());
                    chk("ws24", w24, WS_PAT);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    task automatic goto(input int k, input int j);
        while (cyc < 64 * k + j + 1) tick();
    endtask

    task automatic push(input logic [31:0] l, input logic [31:0] r, input logic [63:0] e);
        logic acc, ok;
        ok = 0;
        in_left = l; in_right = r; in_valid = 1;
        for (int i = 0; i < 300 && !ok; i++) begin
            acc = in_ready;
            tick();
            ok = acc;
        end
        in_valid = 0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL push_timeout: got no accept want accept");
        end else expect_frame(e);
    endtask

    initial begin
        rst = 1;
        repeat (3) tick();
        chk("rst_ws", 64'(ws), 64'd0);
        chk("rst_sd", 64'(sd), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        rst = 0;
        expect_frame(64'd0);
        tick();
        chk("e0_level", 64'(level), 64'd0);
        chk("e0_underrun", 64'(underrun), 64'd0);
        chk("e0_ready", 64'(in_ready), 64'd1);
        push(32'h8000_0001, 32'h7FFF_FFFE, 64'h8000_0001_7FFF_FFFE);
        push(32'hFFFF_FFFF, 32'h1234_5678, 64'hFFFF_FFFF_1234_5678);
        chk("level2", 64'(level), 64'd2);
        expect_frame(64'd0);
        expect_frame(64'd0);
        goto(2, 5);
        chk("f2_underrun", 64'(underrun), 64'd0);
        chk("f2_level", 64'(level), 64'd0);
        goto(3, 1);
        chk("underrun_set", 64'(underrun), 64'd1);
        chk("underrun_set24", 64'(ur24), 64'd1);
        goto(3, 2);
        clr_underrun = 1;
        tick();
        clr_underrun = 0;
        chk("underrun_clr", 64'(underrun), 64'd0);
        goto(3, 63);
        clr_underrun = 1;
        tick();
        clr_underrun = 0;
        chk("set_over_clr", 64'(underrun), 64'd1);
        push(32'hA5A5_A5A5, 32'h0F0F_0F0F, 64'hA5A5_A5A5_0F0F_0F0F);
        push(32'hDEAD_BEEF, 32'hCAFE_F00D, 64'd0);
        push(32'h1111_1111, 32'h2222_2222, 64'h1111_1111_2222_2222);
        push(32'h3333_3333, 32'h4444_4444, 64'h3333_3333_4444_4444);
        chk("full_level", 64'(level), 64'd4);
        chk("full_level24", 64'(lvl24), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        in_left = 32'h5555_5555; in_right = 32'h6666_6666; in_valid = 1;
        goto(4, 63);
        chk("held_ready", 64'(in_ready), 64'd0);
        chk("held_level", 64'(level), 64'd4);
        tick();
        chk("pop_level", 64'(level), 64'd3);
        chk("pop_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 0;
        expect_frame(64'h5555_5555_6666_6666);
        chk("refill_level", 64'(level), 64'd4);
        goto(5, 63);
        mute = 1;
        tick();
        mute = 0;
        chk("mute_level", 64'(level), 64'd3);
        goto(7, 40);
        chk("f40_ws", 64'(ws), 64'd1);
        rst = 1;
        tick();
        chk("mrst_ws", 64'(ws), 64'd0);
        chk("mrst_sd", 64'(sd), 64'd0);
        chk("mrst_level", 64'(level), 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd0);
        chk("mrst_underrun", 64'(underrun), 64'd0);
        q32.delete();
        q24.delete();
        tick();
        tick();
        rst = 0;
        expect_frame(64'd0);
        tick();
        chk("r2_level", 64'(level), 64'd0);
        chk("r2_underrun", 64'(underrun), 64'd0);
        push(32'hC000_0003, 32'h0000_0300, 64'hC000_0003_0000_0300);
        goto(1, 5);
        chk("r2_f1_underrun", 64'(underrun), 64'd0);
        goto(2, 2);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q24_drained", 64'(q24.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
